alu_slice_seq: RTL and testbench

//  Parametrised multi-cycle ALU: WIDTH-bit operands processed one SLICE-bit slice per clock,
//  LSB slice first, with the inter-slice carry held in a register.

---
 rtl/alu_slice_seq.sv | 148 ++++++++++++++
 tb/tb_alu_slice_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_seq.sv
// Multi-cycle ALU that handles WIDTH-bit operands one SLICE-bit slice per clock, LSB first.
// The inter-slice carry is held in a register, and valid/ready handshakes are used on both sides.
module alu_slice_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  state_e state, state_next;

  logic [WIDTH-1:0] a_r, b_r, acc, acc_next, slice_ext, fin_res;
  op_e              op_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             sub_op;
  logic [SLICE-1:0] slice_a, b_eff, slice_res;
  logic [SLICE:0]   sum;
  logic             c_msb, ovf_raw, fin_cout, fin_ovf;

  assign last = (cnt == CW'(NS - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and busy flags are registered from the next state so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next != IDLE);
    end
  end

  always_comb begin
    sub_op  = (op_r == OP_SUB) || (op_r == OP_SLT);
    slice_a = a_r[SLICE-1:0];
    b_eff   = sub_op ? ~b_r[SLICE-1:0] : b_r[SLICE-1:0];
    sum     = {1'b0, slice_a} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry};
    case (op_r)
      OP_AND:                 slice_res = slice_a & b_r[SLICE-1:0];
      OP_OR:                  slice_res = slice_a | b_r[SLICE-1:0];
      OP_ADD, OP_SUB, OP_SLT: slice_res = sum[SLICE-1:0];
      default:                slice_res = '0;
    endcase
    // Operands shift right each cycle; finished slices enter the accumulator from the top.
    slice_ext              = '0;
    slice_ext[SLICE-1:0]   = slice_res;
    acc_next               = (acc >> SLICE) | (slice_ext << (WIDTH - SLICE));
    c_msb                  = slice_a[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];
    ovf_raw                = c_msb ^ sum[SLICE];
    fin_res                = acc_next;
    fin_cout               = 1'b0;
    fin_ovf                = 1'b0;
    case (op_r)
      OP_AND, OP_OR: ;
      OP_ADD, OP_SUB: begin
        fin_cout = sum[SLICE];
        fin_ovf  = ovf_raw;
      end
      OP_SLT: begin
        fin_res    = '0;
        fin_res[0] = sum[SLICE-1] ^ ovf_raw;
      end
      default: fin_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= OP_AND;
      carry    <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          op_r  <= op_e'(op);
          carry <= (op == OP_SUB) || (op == OP_SLT);
          cnt   <= '0;
          acc   <= '0;
        end
        RUN: begin
          a_r   <= a_r >> SLICE;
          b_r   <= b_r >> SLICE;
          acc   <= acc_next;
          carry <= sum[SLICE];
          cnt   <= cnt + CW'(1);
          if (last) begin
            result   <= fin_res;
            cout     <= fin_cout;
            overflow <= fin_ovf;
            zero     <= (fin_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Scoreboard bench for alu_slice_seq (WIDTH=16, SLICE=4). Expected results are queued when
// operations are issued, then popped and compared when the result comes out.
module tb_alu_slice_seq;
  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NS = W / S;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout, overflow, zero, busy;

  alu_slice_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
    res_t r;
    logic [W:0] s;
    r = '0;
    case (o)
      3'b000: r.res = x & y;
      3'b001: r.res = x | y;
      3'b010: begin
        s      = {1'b0, x} + {1'b0, y};
        r.res  = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.res[W-1] != x[W-1]);
      end
      3'b110: begin
        s      = {1'b0, x} + {1'b0, ~y} + 1'b1;
        r.res  = s[W-1:0];
        r.cout = s[W];
        r.ovf  = (x[W-1] != y[W-1]) && (r.res[W-1] != x[W-1]);
      end
      3'b111: r.res = ($signed(x) < $signed(y)) ? 1 : 0;
      default: r.res = '0;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o, input bit push);
    int n = 0;
    while (in_ready !== 1'b1 && n < 32) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 32) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready got %b exp 1", in_ready);
    end
    in_valid = 1'b1; a = x; b = y; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) sb.push_back(model(x, y, o));
  endtask

  task automatic collect(output int lat, output res_t obs);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    obs = {result, cout, overflow, zero};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result, cout, overflow, zero} !== {3'b100, 16'h0000, 3'b001}) begin
      errors++;
      $display("FAIL reset rdy/vld/busy/res/c/v/z got %b%b%b/%h/%b%b%b exp 100/0000/001",
               in_ready, out_valid, busy, result, cout, overflow, zero);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [W-1:0] ta[14] = '{16'h00FF, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h1234, 16'hF0F0,
                            16'hF0F0, 16'hFFFF, 16'h8000, 16'h0003, 16'hABCD, 16'hABCD, 16'hABCD};
    logic [W-1:0] tb_[14] = '{16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h8000, 16'h1234, 16'h0FF0,
                             16'h0FF0, 16'h0001, 16'h8000, 16'hFFFE, 16'h1111, 16'h2222, 16'h3333};
    logic [2:0]   to[14] = '{3'b010, 3'b010, 3'b110, 3'b111, 3'b111, 3'b110, 3'b000,
                            3'b001, 3'b010, 3'b010, 3'b111, 3'b011, 3'b100, 3'b101};
    int lat;
    res_t obs, exp;
    for (int i = 0; i < 14; i++) begin
      send(ta[i], tb_[i], to[i], 1'b1);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ops_busy[%0d] busy/in_ready got %b/%b exp 1/0", i, busy, in_ready);
      end
      collect(lat, obs);
      checks++;
      if (lat != NS) begin
        errors++;
        $display("FAIL ops_latency[%0d] got %0d exp %0d", i, lat, NS);
      end
      exp = sb.pop_front();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ops[%0d] res/c/v/z got %h/%b/%b/%b exp %h/%b/%b/%b", i,
                 obs.res, obs.cout, obs.ovf, obs.zero, exp.res, exp.cout, exp.ovf, exp.zero);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    res_t obs, exp;
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 3'b010, 1'b1);
    collect(lat, obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_result got %h exp %h", obs.res, exp.res);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; op = 3'b010;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, busy, result} !== {3'b101, exp.res}) begin
        errors++;
        $display("FAIL bp_hold[%0d] vld/rdy/busy/res got %b%b%b/%h exp 101/%h",
                 i, out_valid, in_ready, busy, result, exp.res);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, busy, result} !== {3'b010, exp.res}) begin
      errors++;
      $display("FAIL bp_release vld/rdy/busy/res got %b%b%b/%h exp 010/%h",
               out_valid, in_ready, busy, result, exp.res);
    end
    send(16'h0005, 16'h0003, 3'b110, 1'b1);
    collect(lat, obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp || lat != NS) begin
      errors++;
      $display("FAIL bp_next res/lat got %h/%0d exp %h/%0d", obs.res, lat, exp.res, NS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat;
    res_t obs, exp;
    send(16'h4321, 16'h1111, 3'b010, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, result, zero} !== {3'b100, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL abort rdy/vld/busy/res/z got %b%b%b/%h/%b exp 100/0000/1",
               in_ready, out_valid, busy, result, zero);
    end
    reset = 1'b0;
    repeat (NS + 3) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_output out_valid got %b exp 0", out_valid);
      end
    end
    send(16'h0F0F, 16'h0101, 3'b010, 1'b1);
    collect(lat, obs);
    exp = sb.pop_front();
    checks++;
    if (obs !== exp || lat != NS) begin
      errors++;
      $display("FAIL abort_next res/lat got %h/%0d exp %h/%0d", obs.res, lat, exp.res, NS);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops[5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    int lat;
    res_t obs, exp;
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), W'($urandom), ops[$urandom_range(0, 4)], 1'b1);
      collect(lat, obs);
      exp = sb.pop_front();
      checks++;
      if (obs !== exp || lat != NS) begin
        errors++;
        $display("FAIL b2b[%0d] res/c/v/z/lat got %h/%b/%b/%b/%0d exp %h/%b/%b/%b/%0d", i,
                 obs.res, obs.cout, obs.ovf, obs.zero, lat, exp.res, exp.cout, exp.ovf, exp.zero, NS);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle[%0d] rdy/vld got %b/%b exp 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
